simplez_bus_cpu: RTL and testbench

Parametrised next-generation Simplez core. It executes the 8-opcode Simplez ISA plus the extended HALT/WAIT opcodes. RAM and peripherals are reached over an external req/ack bus with arbitrary wait states, so there is no internal RAM and no fixed peripheral map. Data width, address width and WAIT duration are generic. The block sits between the top-level bus decoder (RAM, UART, LEDs) and a debug/step controller.

---
 rtl/simplez_pkg.sv | 41 ++++
 rtl/simplez_wait_timer.sv | 33 +++
 rtl/simplez_bus_cpu.sv | 223 ++++++++++++++++++++++
 tb/tb_simplez_bus_cpu.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/simplez_pkg.sv
// Shared definitions for the Simplez bus core: opcodes, FSM state encoding and
// instruction field extraction helpers that work for any DW/AW combination.
package simplez_pkg;

  localparam int MAX_W = 64;

  localparam logic [2:0] OP_ST   = 3'd0;
  localparam logic [2:0] OP_LD   = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_BR   = 3'd3;
  localparam logic [2:0] OP_BZ   = 3'd4;
  localparam logic [2:0] OP_CLR  = 3'd5;
  localparam logic [2:0] OP_DEC  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  localparam logic [3:0] OP_HALTE = 4'hE;
  localparam logic [3:0] OP_WAIT  = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_MEM    = 3'd3,
    S_WAIT   = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // Callers zero-extend RI to MAX_W and pass their own DW/AW.
  function automatic logic [2:0] get_co(input logic [MAX_W-1:0] ri, input int dw);
    return 3'(ri >> (dw - 3));
  endfunction

  function automatic logic [3:0] get_coe(input logic [MAX_W-1:0] ri, input int dw);
    return 4'(ri >> (dw - 4));
  endfunction

  function automatic logic [MAX_W-1:0] get_cd(input logic [MAX_W-1:0] ri, input int aw);
    return ri & ((MAX_W'(1) << aw) - MAX_W'(1));
  endfunction

endpackage

// File: rtl/simplez_wait_timer.sv
// Down-counter for the WAIT opcode: load sets WAIT_CYCLES-1, count steps it
// towards zero, done flags the final cycle of the wait.
module simplez_wait_timer
  import simplez_pkg::*;
#(
  parameter int WAIT_CYCLES = 2400000
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_load,
  input  logic i_count,
  output logic o_done
);

  localparam int TW = $clog2(WAIT_CYCLES + 1);
  localparam logic [TW-1:0] LOAD_VAL = TW'(WAIT_CYCLES - 1);
  localparam logic [TW-1:0] ONE_TW   = TW'(1);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_count && (r_cnt != '0)) begin
      r_cnt <= r_cnt - ONE_TW;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/simplez_bus_cpu.sv
// Simplez core with an external req/ack bus; fetch and memory operands go over
// the bus, WAIT uses a local down-counter, stepping is gated in IDLE.
module simplez_bus_cpu
  import simplez_pkg::*;
#(
  parameter int DW          = 12,
  parameter int AW          = 9,
  parameter int WAIT_CYCLES = 2400000,
  parameter int RESET_PC    = 0
) (
  input  logic          clk,
  input  logic          rstn,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
  input  logic          bus_ack,
  input  logic          step_en,
  input  logic          step,
  output logic          halted,
  output logic [DW-1:0] acc,
  output logic          flag_z,
  output logic [2:0]    dbg_state
);

  // Bus handshake: bus_req is held with addr/we/wdata stable until a cycle
  // where bus_req and bus_ack are both high (same-cycle ack allowed); the FSM
  // always passes through a non-requesting state between two transfers, and
  // bus_ack outside a request is never looked at.

  localparam logic [DW-1:0] ONE_DW = DW'(1);
  localparam logic [AW-1:0] ONE_AW = AW'(1);

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_pc;
  logic [DW-1:0] r_ri;
  logic [DW-1:0] r_acc;
  logic          r_z;
  logic          r_halted;

  logic [MAX_W-1:0] w_ri_ext;
  logic [2:0]       w_co;
  logic [3:0]       w_coe;
  logic [AW-1:0]    w_cd;
  logic [AW-1:0]    w_pc_inc;
  logic [DW-1:0]    w_dec;
  logic [DW-1:0]    w_sum;
  logic [DW-1:0]    w_mem_val;
  logic             w_xfer_done;
  logic             w_tmr_load;
  logic             w_tmr_count;
  logic             w_tmr_done;

  assign w_ri_ext    = MAX_W'(r_ri);
  assign w_co        = get_co(w_ri_ext, DW);
  assign w_coe       = get_coe(w_ri_ext, DW);
  assign w_cd        = AW'(get_cd(w_ri_ext, AW));
  assign w_pc_inc    = r_pc + ONE_AW;
  assign w_dec       = r_acc - ONE_DW;
  assign w_sum       = r_acc + bus_rdata;
  assign w_mem_val   = (w_co == OP_LD) ? bus_rdata : w_sum;
  assign w_xfer_done = bus_req && bus_ack;

  simplez_wait_timer #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_timer (
    .clk    (clk),
    .rstn   (rstn),
    .i_load (w_tmr_load),
    .i_count(w_tmr_count),
    .o_done (w_tmr_done)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (step_en || step) begin
          w_next = S_FETCH;
        end
      end
      S_FETCH: begin
        if (w_xfer_done) begin
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        case (w_co)
          OP_ST, OP_LD, OP_ADD: w_next = S_MEM;
          OP_HALT: begin
            if (w_coe == OP_HALTE) begin
              w_next = S_HALT;
            end else if (w_coe == OP_WAIT) begin
              w_next = S_WAIT;
            end else begin
              w_next = S_IDLE;
            end
          end
          default: w_next = S_IDLE;
        endcase
      end
      S_MEM: begin
        if (w_xfer_done) begin
          w_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (w_tmr_done) begin
          w_next = S_IDLE;
        end
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus_req     = 1'b0;
    bus_we      = 1'b0;
    bus_addr    = r_pc;
    bus_wdata   = r_acc;
    w_tmr_load  = 1'b0;
    w_tmr_count = 1'b0;
    case (r_state)
      S_FETCH: begin
        bus_req  = 1'b1;
        bus_addr = r_pc;
      end
      S_DECODE: begin
        w_tmr_load = (w_co == OP_HALT) && (w_coe == OP_WAIT);
      end
      S_MEM: begin
        bus_req  = 1'b1;
        bus_we   = (w_co == OP_ST);
        bus_addr = w_cd;
      end
      S_WAIT: begin
        w_tmr_count = 1'b1;
      end
      default: begin
        bus_req = 1'b0;
      end
    endcase
  end

  // Architectural registers; every A write refreshes Z from the new value.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_pc     <= AW'(RESET_PC);
      r_ri     <= '0;
      r_acc    <= '0;
      r_z      <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_xfer_done) begin
            r_ri <= bus_rdata;
          end
        end
        S_DECODE: begin
          case (w_co)
            OP_BR: r_pc <= w_cd;
            OP_BZ: r_pc <= r_z ? w_cd : w_pc_inc;
            OP_CLR: begin
              r_acc <= '0;
              r_z   <= 1'b1;
              r_pc  <= w_pc_inc;
            end
            OP_DEC: begin
              r_acc <= w_dec;
              r_z   <= (w_dec == '0);
              r_pc  <= w_pc_inc;
            end
            OP_HALT: begin
              if (w_coe == OP_HALTE) begin
                r_halted <= 1'b1;
              end else if (w_coe != OP_WAIT) begin
                r_pc <= w_pc_inc;
              end
            end
            default: begin
              r_pc <= r_pc;
            end
          endcase
        end
        S_MEM: begin
          if (w_xfer_done) begin
            if (w_co != OP_ST) begin
              r_acc <= w_mem_val;
              r_z   <= (w_mem_val == '0);
            end
            r_pc <= w_pc_inc;
          end
        end
        S_WAIT: begin
          if (w_tmr_done) begin
            r_pc <= w_pc_inc;
          end
        end
        default: begin
          r_pc <= r_pc;
        end
      endcase
    end
  end

  assign halted    = r_halted;
  assign acc       = r_acc;
  assign flag_z    = r_z;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_simplez_bus_cpu.sv
// Directed bench for simplez_bus_cpu: a table of small programs run against a
// bus responder with programmable wait states, plus stepping/WAIT/reset cases.
module tb_simplez_bus_cpu;
  import simplez_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        bus_req;
  logic        bus_we;
  logic [8:0]  bus_addr;
  logic [11:0] bus_wdata;
  logic [11:0] bus_rdata;
  logic        bus_ack;
  logic        step_en = 1'b1;
  logic        step = 1'b0;
  logic        halted;
  logic [11:0] acc;
  logic        flag_z;
  logic [2:0]  dbg_state;

  logic [11:0] mem [0:511];
  int          ack_delay = 0;
  logic        ack_block = 1'b0;
  int          ack_cnt = 0;

  int n_chk = 0;
  int n_err = 0;

  logic [8:0]  fetch_q[$];
  logic [20:0] wr_q[$];
  int          req_cnt = 0;
  int          wait_cnt = 0;
  int          wait_req = 0;
  int          viol_cnt = 0;
  logic        prev_v = 1'b0;
  logic        prev_req, prev_ack, prev_we;
  logic [8:0]  prev_addr;
  logic [11:0] prev_wdata;

  simplez_bus_cpu #(
    .DW(12), .AW(9), .WAIT_CYCLES(10), .RESET_PC(0)
  ) dut (
    .clk(clk), .rstn(rstn),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .step_en(step_en), .step(step),
    .halted(halted), .acc(acc), .flag_z(flag_z), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Memory/peripheral responder: ack after ack_delay wait cycles.
  assign bus_rdata = mem[bus_addr];
  assign bus_ack   = bus_req && !ack_block && (ack_cnt >= ack_delay);

  always @(posedge clk) begin
    if (bus_req && !bus_ack) ack_cnt <= ack_cnt + 1;
    else                     ack_cnt <= 0;
  end

  // Bus monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rstn) begin
      prev_v = 1'b0;
    end else begin
      if (bus_req) req_cnt++;
      if (dbg_state == 3'(S_WAIT)) begin
        wait_cnt++;
        if (bus_req) wait_req++;
      end
      if (bus_req && bus_ack) begin
        if (bus_we) wr_q.push_back({bus_addr, bus_wdata});
        else if (dbg_state == 3'(S_FETCH)) fetch_q.push_back(bus_addr);
      end
      if (prev_v && prev_req && prev_ack && bus_req) viol_cnt++;
      if (prev_v && prev_req && !prev_ack && bus_req &&
          ((bus_addr != prev_addr) || (bus_we != prev_we) || (bus_wdata != prev_wdata)))
        viol_cnt++;
      prev_v     = 1'b1;
      prev_req   = bus_req;
      prev_ack   = bus_ack;
      prev_we    = bus_we;
      prev_addr  = bus_addr;
      prev_wdata = bus_wdata;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_req",    32'(bus_req),   32'(0));
    check("rst_we",     32'(bus_we),    32'(0));
    check("rst_halted", 32'(halted),    32'(0));
    check("rst_acc",    32'(acc),       32'(0));
    check("rst_z",      32'(flag_z),    32'(0));
    check("rst_state",  32'(dbg_state), 32'(S_IDLE));
    fetch_q.delete();
    wr_q.delete();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic run_to_halt(input int budget, output int cyc);
    cyc = -1;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (halted) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic load_prog(input logic [11:0] p0, input logic [11:0] p1,
                           input logic [11:0] p2, input logic [11:0] p3,
                           input logic [11:0] x, input logic [11:0] y);
    for (int i = 0; i < 512; i++) mem[i] = 12'hE00;
    mem[0] = p0; mem[1] = p1; mem[2] = p2; mem[3] = p3;
    mem[9'h010] = x;
    mem[9'h011] = y;
  endtask

  task automatic step_pulse();
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  typedef struct {
    logic [11:0] p0, p1, p2, p3;
    logic [11:0] x, y;
    int          delay;
    logic [11:0] exp_acc;
    logic        exp_z;
    int          exp_cyc;
    int          exp_wr;
    logic [8:0]  exp_wa;
    logic [11:0] exp_wd;
    logic [8:0]  exp_last;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int          cyc;
    int          req0, viol0, wait0, waitreq0;
    logic [20:0] wtmp;
    logic [8:0]  ftmp;

    vecs[0] = '{12'h210, 12'h411, 12'h012, 12'hE00, 12'd5,   12'd7,   0, 12'h00C, 1'b0, 15, 1, 9'h012, 12'h00C, 9'h003};
    vecs[1] = '{12'h210, 12'h411, 12'h012, 12'hE00, 12'd5,   12'd7,   3, 12'h00C, 1'b0, 36, 1, 9'h012, 12'h00C, 9'h003};
    vecs[2] = '{12'hA00, 12'hC00, 12'h820, 12'hE00, 12'd0,   12'd0,   0, 12'hFFF, 1'b0, 12, 0, 9'h000, 12'h000, 9'h003};
    vecs[3] = '{12'hA00, 12'h820, 12'hE00, 12'hE00, 12'd0,   12'd0,   0, 12'h000, 1'b1,  9, 0, 9'h000, 12'h000, 9'h020};
    vecs[4] = '{12'h210, 12'h411, 12'h012, 12'hE00, 12'hFFF, 12'h001, 1, 12'h000, 1'b1, 22, 1, 9'h012, 12'h000, 9'h003};
    vecs[5] = '{12'h605, 12'hE00, 12'hE00, 12'hE00, 12'd0,   12'd0,   2, 12'h000, 1'b0, 10, 0, 9'h000, 12'h000, 9'h005};

    for (int i = 0; i < 6; i++) begin
      load_prog(vecs[i].p0, vecs[i].p1, vecs[i].p2, vecs[i].p3, vecs[i].x, vecs[i].y);
      ack_delay = vecs[i].delay;
      viol0 = viol_cnt;
      do_reset();
      run_to_halt(200, cyc);
      check($sformatf("v%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cyc));
      check($sformatf("v%0d_acc", i), 32'(acc), 32'(vecs[i].exp_acc));
      check($sformatf("v%0d_z", i), 32'(flag_z), 32'(vecs[i].exp_z));
      req0 = req_cnt;
      repeat (10) @(negedge clk);
      check($sformatf("v%0d_req_after_halt", i), 32'(req_cnt - req0), 32'(0));
      check($sformatf("v%0d_state_halt", i), 32'(dbg_state), 32'(S_HALT));
      check($sformatf("v%0d_bus_protocol", i), 32'(viol_cnt - viol0), 32'(0));
      check($sformatf("v%0d_writes", i), 32'(wr_q.size()), 32'(vecs[i].exp_wr));
      if (vecs[i].exp_wr != 0 && wr_q.size() != 0) begin
        wtmp = wr_q[$];
        check($sformatf("v%0d_wr_addr", i), 32'(wtmp[20:12]), 32'(vecs[i].exp_wa));
        check($sformatf("v%0d_wr_data", i), 32'(wtmp[11:0]), 32'(vecs[i].exp_wd));
      end
      ftmp = (fetch_q.size() != 0) ? fetch_q[$] : 9'h1FF;
      check($sformatf("v%0d_last_fetch", i), 32'(ftmp), 32'(vecs[i].exp_last));
    end

    // WAIT of 10 cycles followed by HALT at PC+1.
    load_prog(12'hF00, 12'hE00, 12'hE00, 12'hE00, 12'd0, 12'd0);
    ack_delay = 0;
    do_reset();
    wait0 = wait_cnt;
    waitreq0 = wait_req;
    run_to_halt(100, cyc);
    check("wait_cycles_total", 32'(cyc), 32'(16));
    check("wait_state_len", 32'(wait_cnt - wait0), 32'(10));
    check("wait_no_req", 32'(wait_req - waitreq0), 32'(0));
    check("wait_fetch_cnt", 32'(fetch_q.size()), 32'(2));
    ftmp = (fetch_q.size() > 1) ? fetch_q[1] : 9'h1FF;
    check("wait_next_fetch", 32'(ftmp), 32'(1));

    // Single stepping with step_en low.
    load_prog(12'hA00, 12'hC00, 12'hC00, 12'hE00, 12'd0, 12'd0);
    step_en = 1'b0;
    do_reset();
    repeat (8) @(negedge clk);
    check("step_idle_fetches", 32'(fetch_q.size()), 32'(0));
    check("step_idle_state", 32'(dbg_state), 32'(S_IDLE));
    step_pulse();
    check("step1_fetches", 32'(fetch_q.size()), 32'(1));
    check("step1_z", 32'(flag_z), 32'(1));
    step_pulse();
    step_pulse();
    check("step3_fetches", 32'(fetch_q.size()), 32'(3));
    check("step3_acc", 32'(acc), 32'(12'hFFE));
    check("step3_z", 32'(flag_z), 32'(0));
    check("step3_state", 32'(dbg_state), 32'(S_IDLE));
    check("step3_halted", 32'(halted), 32'(0));
    step_pulse();
    ftmp = (fetch_q.size() > 3) ? fetch_q[3] : 9'h1FF;
    check("step4_pc", 32'(ftmp), 32'(3));
    check("step4_halted", 32'(halted), 32'(1));
    step_en = 1'b1;

    // Reset while a fetch is stalled, then clean refetch from address 0.
    load_prog(12'h210, 12'h411, 12'h012, 12'hE00, 12'd5, 12'd7);
    ack_block = 1'b1;
    do_reset();
    repeat (3) @(negedge clk);
    check("abort_req_pending", 32'(bus_req), 32'(1));
    check("abort_state_fetch", 32'(dbg_state), 32'(S_FETCH));
    rstn = 1'b0;
    @(negedge clk);
    check("abort_req_low", 32'(bus_req), 32'(0));
    check("abort_state_idle", 32'(dbg_state), 32'(S_IDLE));
    check("abort_acc", 32'(acc), 32'(0));
    check("abort_halted", 32'(halted), 32'(0));
    ack_block = 1'b0;
    fetch_q.delete();
    rstn = 1'b1;
    run_to_halt(100, cyc);
    check("abort_refetch_cycles", 32'(cyc), 32'(15));
    ftmp = (fetch_q.size() != 0) ? fetch_q[0] : 9'h1FF;
    check("abort_refetch_addr", 32'(ftmp), 32'(0));
    check("abort_final_acc", 32'(acc), 32'(12'h00C));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
